// File: rtl/pipe_stage_skid_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the skid-buffered pipeline stage registers:
//               stage state encoding, occupancy codes and per-boundary payloads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [1:0] c_OCC_EMPTY = 2'd0;
  localparam logic [1:0] c_OCC_ONE   = 2'd1;
  localparam logic [1:0] c_OCC_TWO   = 2'd2;

  // Illegal encodings report as empty, matching the recovery state.
  function automatic logic [1:0] occ_of(state_e s);
    case (s)
      ONE:     return c_OCC_ONE;
      TWO:     return c_OCC_TWO;
      default: return c_OCC_EMPTY;
    endcase
  endfunction

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] reg2;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] excepttype;
  } ex_mem_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [31:0] excepttype;
    logic [31:0] pc;
    logic        delayslot;
  } nop2_mem_t;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
  } mem_wb_t;

  localparam int c_EX_MEM_W   = $bits(ex_mem_t);
  localparam int c_NOP2_MEM_W = $bits(nop2_mem_t);
  localparam int c_MEM_WB_W   = $bits(mem_wb_t);

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
// ============================================================================
// Module      : pipe_stage_skid_if
// Description : Valid/ready payload handshake into and out of one stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_skid_if #(
  parameter int DATA_W = 128
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: feeds the stage and consumes its output.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Stage side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear (clear wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_ONE = 1;
  localparam logic [CNT_W-1:0] c_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
// Module      : pipe_stage_skid
// Description : Pipeline stage register with 2-entry skid buffer, registered
//               ready, flush and saturating back-pressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                bp_clear,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    bp_cycles
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [1:0]        r_occ;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      // Any concurrent in_fire is dropped; a concurrent out_fire has completed.
      w_state_nxt = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        w_main_nxt = '0;
        w_skid_nxt = '0;
      end
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_nxt  = bus.in_data;
          end else if (CLEAR_ON_FLUSH) begin
            w_main_nxt = '0;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = bus.in_data;
          end else if (w_in_fire) begin
            w_state_nxt = TWO;
            w_skid_nxt  = bus.in_data;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
            if (CLEAR_ON_FLUSH) begin
              w_main_nxt = '0;
            end
          end
        end
        TWO: begin
          if (w_out_fire) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
            if (CLEAR_ON_FLUSH) begin
              w_skid_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_occ       <= c_OCC_EMPTY;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_out_valid <= (w_state_nxt == ONE) || (w_state_nxt == TWO);
      r_in_ready  <= (w_state_nxt != TWO);
      r_occ       <= occ_of(w_state_nxt);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign occupancy     = r_occ;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (r_out_valid & ~bus.out_ready),
    .clr   (bp_clear),
    .count (bp_cycles)
  );

  // A stalled upstream offer must stay put until it is taken.
  property p_stalled_input_stable;
    @(posedge clk) disable iff (rst)
      (bus.in_valid && !r_in_ready && !flush) |=> (bus.in_valid && $stable(bus.in_data));
  endproperty

  a_stalled_input_stable: assert property (p_stalled_input_stable);

endmodule

`default_nettype wire
